// File: rtl/craft_tweakey_stream.sv
// craft_tweakey_stream: streams CRAFT per-round tweakeys and round constants, LANES rounds per beat; reverse order enabled by CRAFT_TK_INVERSE_EN
module craft_tweakey_stream #(
    parameter int ROUNDS = 32,
    parameter int LANES  = 1
) (
    input  logic                CLK100MHZ,
    input  logic                CPU_RESET,
    input  logic                in_valid,
    output logic                in_ready,
    input  logic [127:0]        key,
    input  logic [63:0]         tweak,
`ifdef CRAFT_TK_INVERSE_EN
    input  logic                dec,
`endif
    output logic                out_valid,
    input  logic                out_ready,
    output logic [64*LANES-1:0] out_tk,
    output logic [8*LANES-1:0]  out_rc,
    output logic [7:0]          out_round,
    output logic                out_last
);
    if (ROUNDS < 1 || ROUNDS > 255 || !(LANES == 1 || LANES == 2 || LANES == 4) || ROUNDS % LANES != 0) begin : g_bad_cfg
        $error("craft_tweakey_stream: ROUNDS must be 1..255 and a multiple of LANES (1, 2 or 4)");
    end

    localparam logic [63:0] PERM = 64'hCAF5E892B374601D;

    function automatic logic [3:0] a_fwd(input logic [3:0] a);
        return {a[0] ^ a[1], a[3:1]};
    endfunction

    function automatic logic [2:0] b_fwd(input logic [2:0] b);
        return {b[0] ^ b[1], b[2:1]};
    endfunction

    function automatic logic [63:0] q_perm(input logic [63:0] t);
        logic [63:0] q;
        q = '0;
        for (int i = 0; i < 16; i++)
            q[63-4*i -: 4] = t[63-4*int'(PERM[63-4*i -: 4]) -: 4];
        return q;
    endfunction

`ifdef CRAFT_TK_INVERSE_EN
    function automatic logic [3:0] a_rev(input logic [3:0] a);
        return {a[2:0], a[3] ^ a[0]};
    endfunction

    function automatic logic [2:0] b_rev(input logic [2:0] b);
        return {b[1:0], b[2] ^ b[0]};
    endfunction

    // LFSR state of the final round, so reverse jobs can start there without stepping at run time
    function automatic logic [6:0] end_state();
        logic [3:0] a;
        logic [2:0] b;
        a = 4'h1;
        b = 3'h1;
        for (int i = 0; i < ROUNDS - 1; i++) begin
            a = a_fwd(a);
            b = b_fwd(b);
        end
        return {a, b};
    endfunction

    localparam logic [6:0] REV_INIT = end_state();
    logic dec_r;
`endif

    typedef enum logic [1:0] {IDLE, LOAD, RUN} state_t;

    state_t       state;
    logic [127:0] key_r;
    logic [63:0]  tweak_r;
    logic [63:0]  tk_r [4];
    logic [7:0]   rnd;
    logic [3:0]   a_r;
    logic [2:0]   b_r;
    logic [3:0]   a_l [LANES+1];
    logic [2:0]   b_l [LANES+1];
    logic [1:0]   sel_l [LANES];
    logic [64*LANES-1:0] tk_c;
    logic [8*LANES-1:0]  rc_c;
    logic         last_c;
    logic [7:0]   rnd_n;

    assign in_ready = (state == IDLE) & ~CPU_RESET;

`ifdef CRAFT_TK_INVERSE_EN
    assign last_c = dec_r ? (rnd == 8'(LANES - 1)) : (rnd + 8'(LANES) == 8'(ROUNDS));
    assign rnd_n  = dec_r ? rnd - 8'(LANES) : rnd + 8'(LANES);
`else
    assign last_c = rnd + 8'(LANES) == 8'(ROUNDS);
    assign rnd_n  = rnd + 8'(LANES);
`endif

    // Unrolled per-lane LFSR steps and tweakey selection for the beat about to be issued
    always_comb begin
        a_l[0] = a_r;
        b_l[0] = b_r;
        tk_c = '0;
        rc_c = '0;
        for (int k = 0; k < LANES; k++) begin
`ifdef CRAFT_TK_INVERSE_EN
            a_l[k+1] = dec_r ? a_rev(a_l[k]) : a_fwd(a_l[k]);
            b_l[k+1] = dec_r ? b_rev(b_l[k]) : b_fwd(b_l[k]);
            sel_l[k] = dec_r ? rnd[1:0] - 2'(k) : rnd[1:0] + 2'(k);
`else
            a_l[k+1] = a_fwd(a_l[k]);
            b_l[k+1] = b_fwd(b_l[k]);
            sel_l[k] = rnd[1:0] + 2'(k);
`endif
            tk_c[64*k +: 64] = tk_r[sel_l[k]];
            rc_c[8*k +: 8]   = {a_l[k], 1'b0, b_l[k]};
        end
    end

    // Job control: accept a key/tweak, precompute the tweakeys, then stream beats under backpressure
    always_ff @(posedge CLK100MHZ) begin
        if (CPU_RESET) begin
            state     <= IDLE;
            out_valid <= 1'b0;
            out_last  <= 1'b0;
            out_round <= '0;
            out_tk    <= '0;
            out_rc    <= '0;
            key_r     <= '0;
            tweak_r   <= '0;
        end else begin
            case (state)
                IDLE: if (in_valid) begin
                    key_r   <= key;
                    tweak_r <= tweak;
`ifdef CRAFT_TK_INVERSE_EN
                    dec_r   <= dec;
`endif
                    state   <= LOAD;
                end
                LOAD: begin
                    tk_r[0] <= key_r[127:64] ^ tweak_r;
                    tk_r[1] <= key_r[63:0] ^ tweak_r;
                    tk_r[2] <= key_r[127:64] ^ q_perm(tweak_r);
                    tk_r[3] <= key_r[63:0] ^ q_perm(tweak_r);
`ifdef CRAFT_TK_INVERSE_EN
                    rnd          <= dec_r ? 8'(ROUNDS - 1) : 8'd0;
                    {a_r, b_r}   <= dec_r ? REV_INIT : {4'h1, 3'h1};
`else
                    rnd          <= 8'd0;
                    {a_r, b_r}   <= {4'h1, 3'h1};
`endif
                    state   <= RUN;
                end
                RUN: if (out_valid && out_ready && out_last) begin
                    state     <= IDLE;
                    out_valid <= 1'b0;
                    out_last  <= 1'b0;
                end else if (!out_valid || out_ready) begin
                    out_valid <= 1'b1;
                    out_tk    <= tk_c;
                    out_rc    <= rc_c;
                    out_round <= rnd;
                    out_last  <= last_c;
                    rnd       <= rnd_n;
                    a_r       <= a_l[LANES];
                    b_r       <= b_l[LANES];
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_craft_tweakey_stream.sv
// tb_craft_tweakey_stream: randomized and directed checks of craft_tweakey_stream against a round-by-round reference model
module tb_craft_tweakey_stream;
    localparam int ROUNDS = 32;
    localparam logic [127:0] KAT_KEY   = 128'h27a6781a43f364bc916708d5fbb5aefe;
    localparam logic [63:0]  KAT_TWEAK = 64'h54cd94ffd0670a58;

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic         in_valid = 1'b0, in_ready, out_valid, out_ready = 1'b1, out_last, dec = 1'b0;
    logic [127:0] key = '0;
    logic [63:0]  tweak = '0, out_tk;
    logic [7:0]   out_rc, out_round;
    logic         in_valid4 = 1'b0, in_ready4, out_valid4, out_ready4 = 1'b1, out_last4, dec4 = 1'b0;
    logic [127:0] key4 = '0;
    logic [63:0]  tweak4 = '0;
    logic [255:0] out_tk4;
    logic [31:0]  out_rc4;
    logic [7:0]   out_round4;
    logic [7:0]   rc_tab [256];
    logic [3:0]   fa;
    logic [2:0]   fb;
    int           perm [16] = '{12, 10, 15, 5, 14, 8, 9, 2, 11, 3, 7, 4, 6, 0, 1, 13};
    int           n_assert = 0, n_fail = 0;

    always #5 clk = ~clk;

    craft_tweakey_stream #(.ROUNDS(ROUNDS), .LANES(1)) u1 (
        .CLK100MHZ(clk), .CPU_RESET(rst), .in_valid(in_valid), .in_ready(in_ready),
        .key(key), .tweak(tweak),
`ifdef CRAFT_TK_INVERSE_EN
        .dec(dec),
`endif
        .out_valid(out_valid), .out_ready(out_ready), .out_tk(out_tk), .out_rc(out_rc),
        .out_round(out_round), .out_last(out_last)
    );

    craft_tweakey_stream #(.ROUNDS(ROUNDS), .LANES(4)) u4 (
        .CLK100MHZ(clk), .CPU_RESET(rst), .in_valid(in_valid4), .in_ready(in_ready4),
        .key(key4), .tweak(tweak4),
`ifdef CRAFT_TK_INVERSE_EN
        .dec(dec4),
`endif
        .out_valid(out_valid4), .out_ready(out_ready4), .out_tk(out_tk4), .out_rc(out_rc4),
        .out_round(out_round4), .out_last(out_last4)
    );

    task automatic chk(input string tag, input logic [255:0] got, input logic [255:0] exp);
        n_assert++;
        assert (got === exp) else begin
            n_fail++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // Tweakey of round r straight from its definition: K0/K1 alternate, T/Q(T) alternate in pairs
    function automatic logic [63:0] tk_of(input logic [127:0] k, input logic [63:0] t, input int r);
        logic [63:0] q;
        q = '0;
        for (int i = 0; i < 16; i++) q[63-4*i -: 4] = t[63-4*perm[i] -: 4];
        return ((r % 2) ? k[63:0] : k[127:64]) ^ (((r % 4) >= 2) ? q : t);
    endfunction

    // One LANES=1 job; entered and left on a negedge, stalls beat 5 for three cycles
    task automatic run_job(input logic [127:0] k, input logic [63:0] t, input logic d, input logic rnd_ready,
                           input logic hold, input logic [127:0] nk, input logic [63:0] nt);
        int i, r, stall, cyc;
        logic hs;
        in_valid = 1'b1;
        key = k;
        tweak = t;
        dec = d;
        chk("accept_ready", in_ready, 1);
        @(negedge clk);
        if (hold) begin
            key = nk;
            tweak = nt;
        end else in_valid = 1'b0;
        chk("load_gap", out_valid, 0);
        @(negedge clk);
        chk("run_gap", out_valid, 0);
        @(negedge clk);
        i = 0;
        stall = 0;
        cyc = 0;
        while (i < ROUNDS && cyc < 400) begin
            r = d ? ROUNDS - 1 - i : i;
            chk("valid", out_valid, 1);
            chk("round", out_round, r);
            chk("tk", out_tk, tk_of(k, t, r));
            chk("rc", out_rc, rc_tab[r]);
            chk("last", out_last, i == ROUNDS - 1);
            if (i < 2 && k == KAT_KEY && !d) begin
                chk("kat_tk", out_tk, i ? 64'hc5aa9c2a2bd2a4a6 : 64'h736bece593946ee4);
                chk("kat_rc", out_rc, i ? 8'h84 : 8'h11);
            end
            if (i == 5 && stall < 3) begin
                out_ready = 1'b0;
                stall++;
            end else out_ready = rnd_ready ? 1'($urandom_range(0, 1)) : 1'b1;
            hs = out_valid && out_ready;
            @(negedge clk);
            if (hs) i++;
            cyc++;
        end
        chk("beats", i, ROUNDS);
        if (!rnd_ready) chk("throughput", cyc, ROUNDS + 3);
        chk("end_valid", out_valid, 0);
        chk("end_ready", in_ready, 1);
        out_ready = 1'b1;
    endtask

    // One LANES=4 job with out_ready held high
    task automatic run4(input logic [127:0] k, input logic [63:0] t);
        int j, cyc;
        in_valid4 = 1'b1;
        key4 = k;
        tweak4 = t;
        out_ready4 = 1'b1;
        @(negedge clk);
        in_valid4 = 1'b0;
        j = 0;
        cyc = 0;
        while (j < 8 && cyc < 100) begin
            if (out_valid4) begin
                chk("l4_round", out_round4, 4 * j);
                for (int l = 0; l < 4; l++) begin
                    chk("l4_tk", out_tk4[64*l +: 64], tk_of(k, t, 4 * j + l));
                    chk("l4_rc", out_rc4[8*l +: 8], rc_tab[4*j+l]);
                end
                chk("l4_last", out_last4, j == 7);
                if (j == 0) chk("l4_rc_beat0", out_rc4, 32'h25428411);
                j++;
            end
            @(negedge clk);
            cyc++;
        end
        chk("l4_beats", j, 8);
        chk("l4_done", out_valid4, 0);
    endtask

    initial begin
        logic [127:0] ka, kb;
        logic [63:0]  ta, tb;
        int cyc;
        fa = 4'h1;
        fb = 3'h1;
        for (int r = 0; r < 256; r++) begin
            rc_tab[r] = {fa, 1'b0, fb};
            fa = {fa[0] ^ fa[1], fa[3:1]};
            fb = {fb[0] ^ fb[1], fb[2:1]};
        end
        repeat (2) @(negedge clk);
        chk("rst_in_ready", in_ready, 0);
        chk("rst_valid", out_valid, 0);
        chk("rst_last", out_last, 0);
        chk("rst_round", out_round, 0);
        chk("rst_tk", out_tk, 0);
        chk("rst_rc", out_rc, 0);
        chk("rst_valid4", out_valid4, 0);
        rst = 1'b0;
        #1;
        chk("idle_ready", in_ready, 1);
        @(negedge clk);

        run_job(KAT_KEY, KAT_TWEAK, 1'b0, 1'b0, 1'b0, '0, '0);
        ka = {$urandom, $urandom, $urandom, $urandom};
        ta = {$urandom, $urandom};
        run_job(ka, ta, 1'b0, 1'b1, 1'b0, '0, '0);

        in_valid = 1'b1;
        key = {$urandom, $urandom, $urandom, $urandom};
        tweak = {$urandom, $urandom};
        dec = 1'b0;
        out_ready = 1'b1;
        @(negedge clk);
        in_valid = 1'b0;
        cyc = 0;
        while (!(out_valid && out_round == 8'd10) && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk("reach_r10", out_round, 10);
        rst = 1'b1;
        @(negedge clk);
        chk("abort_valid", out_valid, 0);
        chk("abort_round", out_round, 0);
        chk("abort_in_ready", in_ready, 0);
        rst = 1'b0;
        #1;
        chk("abort_ready_back", in_ready, 1);
        @(negedge clk);
        chk("abort_no_beat", out_valid, 0);
        run_job(ka, ta, 1'b0, 1'b0, 1'b0, '0, '0);

        kb = {$urandom, $urandom, $urandom, $urandom};
        tb = {$urandom, $urandom};
        run_job(ka, ta, 1'b0, 1'b1, 1'b1, kb, tb);
        run_job(kb, tb, 1'b0, 1'b0, 1'b0, '0, '0);

        run4(KAT_KEY, KAT_TWEAK);
        run4(kb, tb);

`ifdef CRAFT_TK_INVERSE_EN
        run_job(ka, ta, 1'b1, 1'b0, 1'b0, '0, '0);
        run_job(kb, tb, 1'b1, 1'b1, 1'b0, '0, '0);
        run_job(ka, ta, 1'b0, 1'b0, 1'b0, '0, '0);
`endif

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end
endmodule
